// File: rtl/instr_fetch_reg.sv
// Instruction fetch and instruction register stage: one ready-handshaked word read per request,
// latched into IR and presented as decoded instruction fields.
//
// state  | meaning
// IDLE   | no read in flight; accepts fetch_start
// REQ    | mem_req held with a stable address until ready, flush or timeout
module instr_fetch_reg #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] IR_RESET = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        fetch_start_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        fetch_done_o,
  output logic        fetch_err_o,
  output logic        ir_valid_o,
  output logic [31:0] instruction_o,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] immediate_o,
  output logic [25:0] jump_target_o
);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] ir_q, ir_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        ir_valid_q, ir_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pc_aligned;

  assign pc_aligned = (pc_i[1:0] == 2'b00);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (fetch_start_i && !flush_i && pc_aligned) state_d = S_REQ;
      S_REQ:  if (flush_i || mem_ready_i || (wait_cnt_q == TIMEOUT_C)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o = (state_q == S_REQ);
    busy_o    = (state_q == S_REQ);
  end

  // Flush outranks both a new request in IDLE and a returning word in REQ.
  always_comb begin
    addr_d     = addr_q;
    ir_d       = ir_q;
    wait_cnt_d = wait_cnt_q;
    ir_valid_d = ir_valid_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          ir_valid_d = 1'b0;
        end else if (fetch_start_i) begin
          ir_valid_d = 1'b0;
          if (pc_aligned) begin
            addr_d     = pc_i;
            wait_cnt_d = 8'd1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (flush_i) begin
          ir_valid_d = 1'b0;
        end else if (mem_ready_i) begin
          ir_d       = mem_rdata_i;
          ir_valid_d = 1'b1;
          done_d     = 1'b1;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          ir_valid_d = 1'b0;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      addr_q     <= 32'h0000_0000;
      ir_q       <= IR_RESET;
      wait_cnt_q <= 8'd0;
      ir_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      ir_q       <= ir_d;
      wait_cnt_q <= wait_cnt_d;
      ir_valid_q <= ir_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_addr_o    = addr_q;
  assign fetch_done_o  = done_q;
  assign fetch_err_o   = err_q;
  assign ir_valid_o    = ir_valid_q;
  assign instruction_o = ir_q;
  assign opcode_o      = ir_q[31:26];
  assign rs_o          = ir_q[25:21];
  assign rt_o          = ir_q[20:16];
  assign rd_o          = ir_q[15:11];
  assign shamt_o       = ir_q[10:6];
  assign funct_o       = ir_q[5:0];
  assign immediate_o   = ir_q[15:0];
  assign jump_target_o = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: the driver predicts each fetch outcome from the
// flush/ready/timeout rules and queues it; a monitor checks every done/err pulse against the queue.
module tb_instr_fetch_reg;
  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        fetch_start_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        flush_i = 1'b0;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_req_o, busy_o, fetch_done_o, fetch_err_o, ir_valid_o;
  logic [31:0] mem_addr_o, instruction_o;
  logic [5:0]  opcode_o, funct_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
  logic [15:0] immediate_o;
  logic [25:0] jump_target_o;

  instr_fetch_reg #(.TIMEOUT(TO), .IR_RESET(32'h0000_0000)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .fetch_start_i(fetch_start_i), .pc_i(pc_i),
    .flush_i(flush_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
    .fetch_done_o(fetch_done_o), .fetch_err_o(fetch_err_o), .ir_valid_o(ir_valid_o),
    .instruction_o(instruction_o), .opcode_o(opcode_o), .rs_o(rs_o), .rt_o(rt_o),
    .rd_o(rd_o), .shamt_o(shamt_o), .funct_o(funct_o), .immediate_o(immediate_o),
    .jump_target_o(jump_target_o)
  );

  always #5 clk_i = ~clk_i;

  // kind: 1 = fetch_done, 2 = fetch_err
  typedef struct {
    int          kind;
    logic [31:0] ir;
    logic        valid;
    int          req_len;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_ir = 32'h0000_0000;
  logic        m_valid = 1'b0;
  logic [31:0] exp_addr = '0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Monitor: length of the REQ burst that just ended, address stability, pulse contents.
  int   req_cnt = 0;
  bit   req_prev = 1'b0;
  int   seen = 0;
  int   mon_kind;
  exp_t mon_e;

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, exp_addr);
        req_cnt++;
        req_prev = 1'b1;
        seen = 0;
      end else begin
        seen = req_prev ? req_cnt : 0;
        req_cnt = 0;
        req_prev = 1'b0;
      end
      if (fetch_done_o || fetch_err_o) begin
        mon_kind = fetch_done_o ? (fetch_err_o ? 3 : 1) : 2;
        if (sb_q.size() == 0) begin
          chk("unexpected_pulse", 32'(mon_kind), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("pulse_kind", 32'(mon_kind), 32'(mon_e.kind));
          chk("req_cycles", 32'(seen), 32'(mon_e.req_len));
          chk("instruction", instruction_o, mon_e.ir);
          chk("ir_valid", 32'(ir_valid_o), 32'(mon_e.valid));
          chk("busy_at_pulse", 32'(busy_o), 32'd0);
          chk("opcode", 32'(opcode_o), 32'(mon_e.ir[31:26]));
          chk("rs", 32'(rs_o), 32'(mon_e.ir[25:21]));
          chk("rt", 32'(rt_o), 32'(mon_e.ir[20:16]));
          chk("rd", 32'(rd_o), 32'(mon_e.ir[15:11]));
          chk("shamt", 32'(shamt_o), 32'(mon_e.ir[10:6]));
          chk("funct", 32'(funct_o), 32'(mon_e.ir[5:0]));
          chk("immediate", 32'(immediate_o), 32'(mon_e.ir[15:0]));
          chk("jump_target", 32'(jump_target_o), 32'(mon_e.ir[25:0]));
        end
      end
    end
  end

  // delay: ready arrives on REQ cycle delay+1; flush_at: REQ cycle carrying flush (0 = none).
  task automatic do_fetch(input logic [31:0] pc, input int delay, input int flush_at,
                          input bit flush_start, input logic [31:0] word, input bit noise);
    exp_t e;
    int   kind;
    int   r;
    kind = 0;
    r    = 0;
    if (flush_start) begin
      kind = 0;
    end else if (pc[1:0] != 2'b00) begin
      kind = 2;
    end else begin
      for (int k = 1; k <= TO; k++) begin
        if (k == flush_at)  begin kind = 0; r = k; break; end
        if (k == delay + 1) begin kind = 1; r = k; break; end
        if (k == TO)        begin kind = 2; r = k; break; end
      end
    end
    if (kind == 1) begin
      m_ir    = word;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (kind != 0) begin
      e.kind = kind; e.ir = m_ir; e.valid = m_valid; e.req_len = r;
      sb_q.push_back(e);
    end
    if (!flush_start && pc[1:0] == 2'b00) exp_addr = pc;

    fetch_start_i = 1'b1;
    pc_i          = pc;
    flush_i       = flush_start;
    tick();
    fetch_start_i = 1'b0;
    flush_i       = 1'b0;
    if (flush_start) begin
      @(negedge clk_i);
      chk("flush_start_mem_req", 32'(mem_req_o), 32'd0);
      chk("flush_start_busy", 32'(busy_o), 32'd0);
      chk("flush_start_ir_valid", 32'(ir_valid_o), 32'd0);
      return;
    end
    for (int k = 1; k <= r; k++) begin
      fetch_start_i = noise && ($urandom_range(0, 1) == 1);
      pc_i          = $urandom;
      mem_ready_i   = (k == delay + 1);
      mem_rdata_i   = (k == delay + 1) ? word : $urandom;
      flush_i       = (k == flush_at);
      tick();
    end
    fetch_start_i = 1'b0;
    mem_ready_i   = 1'b0;
    flush_i       = 1'b0;
    if (kind == 0) begin
      @(negedge clk_i);
      chk("flush_busy", 32'(busy_o), 32'd0);
      chk("flush_no_done", 32'(fetch_done_o), 32'd0);
      chk("flush_no_err", 32'(fetch_err_o), 32'd0);
      chk("flush_ir_kept", instruction_o, m_ir);
      chk("flush_ir_valid", 32'(ir_valid_o), 32'd0);
    end
  endtask

  task automatic idle(input bit fl);
    flush_i = fl;
    tick();
    flush_i = 1'b0;
    if (fl) begin
      m_valid = 1'b0;
      @(negedge clk_i);
      chk("idle_flush_ir_valid", 32'(ir_valid_o), 32'd0);
      chk("idle_flush_ir_kept", instruction_o, m_ir);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int          fl_at;

    for (int i = 0; i < 2; i++) begin
      fetch_start_i = 1'($urandom);
      pc_i          = $urandom;
      flush_i       = 1'($urandom);
      mem_ready_i   = 1'($urandom);
      mem_rdata_i   = $urandom;
      tick();
    end
    @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_fetch_done", 32'(fetch_done_o), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err_o), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid_o), 32'd0);
    chk("rst_instruction", instruction_o, 32'h0000_0000);
    chk("rst_opcode", 32'(opcode_o), 32'd0);
    chk("rst_immediate", 32'(immediate_o), 32'd0);
    chk("rst_jump_target", 32'(jump_target_o), 32'd0);
    fetch_start_i = 1'b0;
    flush_i       = 1'b0;
    mem_ready_i   = 1'b0;
    reset_i       = 1'b1;
    mon_en        = 1'b1;
    idle(1'b0);

    do_fetch(32'h0040_0000, 0, 0, 1'b0, 32'h2009_FFFF, 1'b0);
    idle(1'b0);
    do_fetch(32'h0040_0004, 3, 0, 1'b0, 32'h3C01_1234, 1'b1);
    idle(1'b0);
    do_fetch(32'h0040_0008, TO, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    idle(1'b0);
    do_fetch(32'h0040_000C, 3, 0, 1'b0, 32'h0123_4567, 1'b0);
    do_fetch(32'h0040_0010, 1, 2, 1'b0, 32'hFFFF_0000, 1'b0);
    idle(1'b0);
    do_fetch(32'h0040_0002, 0, 0, 1'b0, 32'h0, 1'b0);
    idle(1'b0);
    do_fetch(32'h0040_0014, 0, 0, 1'b1, 32'h0, 1'b0);
    do_fetch(32'h0040_0018, TO - 1, 0, 1'b0, 32'h8C22_0004, 1'b0);
    idle(1'b1);

    for (int t = 0; t < 300; t++) begin
      pc = $urandom;
      if ($urandom_range(0, 6) != 0) pc[1:0] = 2'b00;
      fl_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TO)) : 0;
      do_fetch(pc, int'($urandom_range(0, TO)), fl_at, ($urandom_range(0, 19) == 0),
               $urandom, 1'($urandom));
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle($urandom_range(0, 7) == 0);
    end

    for (int i = 0; i < 3; i++) idle(1'b0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
